// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - dual-read/dual-write register file with overflow flag and load scoreboard (GPR_BYPASS_EN enables same-cycle write-to-read forwarding)
module gpr_file_sb #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter int          GP_REG  = 28,
    parameter logic [31:0] GP_INIT = 32'h0000_1800,
    parameter int          SP_REG  = 29,
    parameter logic [31:0] SP_INIT = 32'h0000_2ffc,
    parameter int          OVF_REG = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     ra,
    input  logic [ADDR_W-1:0]     rb,
    output logic [DATA_W-1:0]     busa,
    output logic [DATA_W-1:0]     busb,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     rw,
    input  logic [DATA_W-1:0]     busw,
    input  logic                  we2,
    input  logic [ADDR_W-1:0]     rw2,
    input  logic [DATA_W-1:0]     busw2,
    input  logic                  OF,
    input  logic                  iss_ld,
    input  logic [ADDR_W-1:0]     iss_rd,
    output logic                  stall_a,
    output logic                  stall_b,
    output logic [(1<<ADDR_W)-1:0] busy
);

    localparam int NREG = 1 << ADDR_W;

    // Reset values are truncated or zero-extended to the datapath width
    localparam logic [DATA_W-1:0] GP_RST = DATA_W'(GP_INIT);
    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

    logic [DATA_W-1:0] regs    [NREG];
    logic [DATA_W-1:0] reg_nxt [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_nxt;

    // Next register contents: port 1 wins a collision, OF forces bit 0 of the overflow register on top of any write
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            reg_nxt[i] = regs[i];
            if (i == 0) begin
                reg_nxt[i] = '0;
            end else begin
                if (we && rw == ADDR_W'(i)) begin
                    reg_nxt[i] = busw;
                end else if (we2 && rw2 == ADDR_W'(i)) begin
                    reg_nxt[i] = busw2;
                end
                if (OF && i == OVF_REG) begin
                    reg_nxt[i][0] = 1'b1;
                end
            end
        end
    end

    // Register storage with asynchronous reset to the GP/SP initial values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                if (i == GP_REG && i != 0) begin
                    regs[i] <= GP_RST;
                end else if (i == SP_REG && i != 0) begin
                    regs[i] <= SP_RST;
                end else begin
                    regs[i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= reg_nxt[i];
            end
        end
    end

    // Scoreboard update: load return clears, a new issue sets and wins over a same-index clear
    always_comb begin
        busy_nxt = busy_q;
        if (we2) begin
            busy_nxt[rw2] = 1'b0;
        end
        if (iss_ld) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state; reset forgets every outstanding load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy = busy_q;

    // Read port A data and stall, optionally forwarding a same-cycle write
    always_comb begin
        busa    = (ra == '0) ? '0 : regs[ra];
        stall_a = (ra != '0) && busy_q[ra];
`ifdef GPR_BYPASS_EN
        if (ra != '0) begin
            if (we && rw == ra) begin
                busa = busw;
            end else if (we2 && rw2 == ra) begin
                busa = busw2;
            end
            if (we2 && rw2 == ra) begin
                stall_a = 1'b0;
            end
        end
`endif
    end

    // Read port B data and stall, optionally forwarding a same-cycle write
    always_comb begin
        busb    = (rb == '0) ? '0 : regs[rb];
        stall_b = (rb != '0) && busy_q[rb];
`ifdef GPR_BYPASS_EN
        if (rb != '0) begin
            if (we && rw == rb) begin
                busb = busw;
            end else if (we2 && rw2 == rb) begin
                busb = busw2;
            end
            if (we2 && rw2 == rb) begin
                stall_b = 1'b0;
            end
        end
`endif
    end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Next-generation general-purpose register file for the single-cycle/in-order core.
- Parametrised in data width and register count.
- Two combinational read ports with optional write-to-read bypass, and two synchronous write ports: ALU/WB and load return.
- Sticky overflow status register, plus a busy-bit scoreboard that flags reads of registers with an outstanding load.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register index width; NREG = 2**ADDR_W
- GP_REG, 28, index of global pointer register
- GP_INIT, 32'h0000_1800, reset value of GP_REG (truncated/zero-extended to DATA_W)
- SP_REG, 29, index of stack pointer register
- SP_INIT, 32'h0000_2ffc, reset value of SP_REG
- OVF_REG, 30, index of overflow status register

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- ra  in  ADDR_W  read port A index
- rb  in  ADDR_W  read port B index
- busa  out  DATA_W  read port A data
- busb  out  DATA_W  read port B data
- we  in  1  write port 1 (ALU/WB) enable
- rw  in  ADDR_W  write port 1 index
- busw  in  DATA_W  write port 1 data
- we2  in  1  write port 2 (load return) enable
- rw2  in  ADDR_W  write port 2 index
- busw2  in  DATA_W  write port 2 data
- OF  in  1  arithmetic overflow pulse, sampled on clk
- iss_ld  in  1  load issued; marks iss_rd busy
- iss_rd  in  ADDR_W  destination of issued load
- stall_a  out  1  port A reads a busy register
- stall_b  out  1  port B reads a busy register
- busy  out  NREG  scoreboard vector, bit i = register i pending

Behaviour:
- Reset (async, immediate):
  - All registers 0, except reg[GP_REG]=GP_INIT and reg[SP_REG]=SP_INIT.
  - busy = 0, so stall_a = stall_b = 0.
  - busa/busb reflect the reset contents combinationally.
- Register 0: reads always 0. Writes, busy marking and bypass to index 0 are ignored.
- Reads: combinational, zero latency; busa = reg[ra], busb = reg[rb].
- Writes: take effect on the rising clk edge. Result visible on busa/busb from the next cycle (or the same cycle with bypass, see Optional Feature).
- Write collision (we && we2 && rw==rw2 != 0): port 1 value stored, busw2 discarded. The busy bit for that index is still cleared by we2.
- OF: synchronous, not an edge-triggered reset-like input. When OF=1 at a clk edge, bit 0 of reg[OVF_REG] is set; other bits keep their value.
- OF with a same-cycle write to OVF_REG: the stored value is busw (or busw2) with bit 0 forced to 1.
- Scoreboard:
  - iss_ld at an edge sets busy[iss_rd] (iss_rd != 0).
  - we2 at an edge clears busy[rw2].
  - Set and clear of the same index in the same cycle: busy stays 1, because the new issue wins.
  - we (port 1) does not affect busy.
- Stall outputs: stall_a = busy[ra] and stall_b = busy[rb], combinational. Both are forced to 0 for index 0.
- Reset asserted mid-operation: all busy bits cleared immediately and all pending loads forgotten. A subsequent we2 writes its data normally and has no scoreboard effect.

Optional Feature:
- Macro: GPR_BYPASS_EN.
- Defined: a same-cycle write forwards to the read ports.
  - If we && rw==ra != 0, busa = busw; port 2 likewise with busw2. Port 1 has priority on a dual match.
  - stall_a/stall_b are masked to 0 when the matching we2 is present that cycle.
  - The OVF_REG bit-0 forcing from OF is NOT forwarded.
- Undefined: reads return stored contents only, and stalls are pure busy lookups.

Test Plan:
- Reset check: pulse reset between edges -> busa(ra=28)=32'h1800, busb(rb=29)=32'h2ffc, all other indices 0, busy=0, without a clock edge.
- Write and r0: we=1, rw=5, busw=32'hDEAD_BEEF, then rw=0, busw=32'h1234 -> reg5 reads DEAD_BEEF next cycle; ra=0 reads 0.
- Dual-write collision: we=we2=1, rw=rw2=7, busw=32'h1, busw2=32'h2 -> reg7=1; busy[7] cleared if it was set.
- Scoreboard: iss_ld=1, iss_rd=9; next cycle ra=9 -> stall_a=1. Then we2=1, rw2=9, busw2=32'h55 -> stall_a=0 after the edge, reg9=32'h55. Same-cycle iss_ld on rd=9 with we2 on rd=9 -> busy[9] stays 1.
- Overflow: reg30=32'h10, OF=1 one cycle -> reg30=32'h11. OF with we, rw=30, busw=32'h40 -> reg30=32'h41.
- Bypass (GPR_BYPASS_EN): we=1, rw=3, busw=32'hA5, ra=3 in the same cycle -> busa=32'hA5 before the edge. Without the macro -> busa shows the old value.
